avalon_arbiter2: RTL and testbench
==================================

# avalon_arbiter2

Two-host round-robin arbiter sharing one Avalon-MM agent, typically the on-chip `avalon_bram`, between two hosts, for example a CPU and a DMA/video reader. The arbiter grants one host at a time and holds the grant for one complete transaction, including multi-beat bursts. Granted host signals pass combinationally to the agent. The non-granted host is stalled with `waitrequest`.

## Interface
- `BURSTCOUNT_W`, default 1: burstcount width; max burst is 2**(BURSTCOUNT_W-1) beats.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `hN_address`  in  32 (N = 0, 1): host N byte address.
- `hN_read`, `hN_write`  in  1: host N commands.
- `hN_writedata`  in  32: host N write data.
- `hN_byteenable`  in  4: host N byte lanes.
- `hN_burstcount`  in  BURSTCOUNT_W: host N burst length.
- `hN_waitrequest`  out  1: stall to host N.
- `hN_readdata`  out  32: read data to host N.
- `hN_readdatavalid`  out  1: read beat valid to host N.
- `a_address`, `a_read`, `a_write`, `a_writedata`, `a_byteenable`, `a_burstcount`  out: to the agent, same widths as the host ports.
- `a_waitrequest`, `a_readdata`, `a_readdatavalid`  in: from the agent.
- `grant`  out  2: one-hot current owner; 00 in IDLE.

## Operation
- FSM states: IDLE, WR, RD_REQ, RD_DATA. Registers:
  - `owner` (1 bit)
  - `last` (1 bit, last granted host)
  - `beats` (BURSTCOUNT_W bits)
  - `len` (BURSTCOUNT_W bits)
- **IDLE:** host N is requesting when `hN_read | hN_write`.
  - One requester: it wins.
  - Both requesting: the host with `!last` wins.
  - On a win: `owner` and `last` take the winner. Next state is WR if the winner's `write` is high, otherwise RD_REQ.
  - If read and write are both high, the write wins. Asserting both is illegal and is flagged by an assertion.
- **Muxing when not IDLE:**
  - All `a_*` command outputs equal the owner's inputs.
  - Owner `waitrequest` = `a_waitrequest`; the other host's `waitrequest` = 1.
- **IDLE outputs:** all `a_*` commands are 0 and both `hN_waitrequest` are 1.
- **WR:** a beat is accepted when `a_write & !a_waitrequest`.
  - On the first beat, `len` takes the owner's burstcount; burstcount 0 is treated as 1.
  - `beats` increments on each accepted beat.
  - When the beat with `beats == len-1` is accepted: `beats` is cleared and the next state is IDLE.
- **RD_REQ:** the command is accepted when `a_read & !a_waitrequest`.
  - `len` is latched (0 → 1) and the next state is RD_DATA.
  - In RD_DATA, `a_read` is forced to 0.
- **RD_DATA:**
  - `hOwner_readdata` = `a_readdata` and `hOwner_readdatavalid` = `a_readdatavalid`.
  - The other host gets readdata 0 and readdatavalid 0.
  - `beats` counts valid beats. After beat `len-1`, `beats` is cleared and the next state is IDLE.
  - Owner `waitrequest` = 1 in this state.
- **Abandon:** if the owner deasserts both read and write in WR (before the first beat) or in RD_REQ, the next state is IDLE. `last` keeps the winner.
- **Stray readdata:** `a_readdatavalid` outside RD_DATA is dropped. Both `hN_readdatavalid` stay 0.

## Timing
- **Reset values** (reset asynchronous, combinational outputs settle at once):
  - state IDLE, `last` = 1 (host 0 wins the first tie), `owner` 0, `beats` 0, `len` 0
  - all `a_*` commands 0
  - `hN_waitrequest` 1, `hN_readdatavalid` 0, `hN_readdata` 0, `grant` 00
- **Grant latency:** request at edge k → grant registered at edge k+1. Forwarding to the agent is combinational from k+1, so the minimum arbitration cost is 1 cycle per transaction.
- **Back-to-back:** the cycle after the last write beat or last read beat, the FSM is in IDLE. The next grant occurs one edge later, so there is 1 idle cycle between transactions.
- **Burst interaction with the agent:**
  - Each write beat is held until `!a_waitrequest`.
  - Read data beats may arrive with gaps.
  - Completion is counted only on valid beats.
- **Reset asserted mid-burst:** the transaction aborts immediately, `a_read`/`a_write` drop without waiting for an edge, and the FSM returns to IDLE.
- **Fairness:** under continuous requests from both hosts, grants strictly alternate 0,1,0,1…

## Test plan
- **Reset:** drive `reset_n`=0 with both hosts requesting → `grant`=00, `a_read`=`a_write`=0, both `hN_waitrequest`=1. After release, host 0 is granted first.
- **Single write:** h0 write, addr 0x10, data 0xDEADBEEF, be 0xF → `grant`=01 one cycle later, `a_*` mirror h0, IDLE after 1 accepted beat. Readback via h1 returns 0xDEADBEEF with `h1_readdatavalid` only.
- **Contention:** h0 and h1 both read continuously for 6 transactions → grant order 0,1,0,1,0,1. The non-owner `waitrequest` stays 1 throughout.
- **Burst (BURSTCOUNT_W=3):** h1 write burst of 4 beats with agent waitrequest toggling → exactly 4 accepted beats, no h0 grant mid-burst. Then an h1 read burst of 4 returns 4 beats only to h1.
- **Abandon and reset:**
  - h0 requests then drops before acceptance → FSM returns to IDLE and h1 is granted next.
  - `reset_n` asserted during RD_DATA → outputs reach reset values without waiting for a clock edge.

Source files
------------

// File: rtl/avalon_arbiter2.sv
// avalon_arbiter2: two-host round-robin arbiter in front of one Avalon-MM agent.
// The grant is held for a whole transaction (including bursts). Granted host
// signals pass combinationally to the agent; the other host is stalled.
module avalon_arbiter2 #(
  parameter int BURSTCOUNT_W = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  // host 0
  input  logic [31:0]             h0_address,
  input  logic                    h0_read,
  input  logic                    h0_write,
  input  logic [31:0]             h0_writedata,
  input  logic [3:0]              h0_byteenable,
  input  logic [BURSTCOUNT_W-1:0] h0_burstcount,
  output logic                    h0_waitrequest,
  output logic [31:0]             h0_readdata,
  output logic                    h0_readdatavalid,
  // host 1
  input  logic [31:0]             h1_address,
  input  logic                    h1_read,
  input  logic                    h1_write,
  input  logic [31:0]             h1_writedata,
  input  logic [3:0]              h1_byteenable,
  input  logic [BURSTCOUNT_W-1:0] h1_burstcount,
  output logic                    h1_waitrequest,
  output logic [31:0]             h1_readdata,
  output logic                    h1_readdatavalid,
  // agent
  output logic [31:0]             a_address,
  output logic                    a_read,
  output logic                    a_write,
  output logic [31:0]             a_writedata,
  output logic [3:0]              a_byteenable,
  output logic [BURSTCOUNT_W-1:0] a_burstcount,
  input  logic                    a_waitrequest,
  input  logic [31:0]             a_readdata,
  input  logic                    a_readdatavalid,
  output logic [1:0]              grant
);

  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD_REQ, S_RD_DATA} state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_owner, w_owner_nxt;
  logic                    r_last, w_last_nxt;
  logic [BURSTCOUNT_W-1:0] r_beats, w_beats_nxt;
  logic [BURSTCOUNT_W-1:0] r_len, w_len_nxt;

  logic                    w_h0_req, w_h1_req, w_win;
  logic [31:0]             w_o_address, w_o_writedata;
  logic                    w_o_read, w_o_write;
  logic [3:0]              w_o_byteenable;
  logic [BURSTCOUNT_W-1:0] w_o_burstcount, w_bc_norm, w_len_eff;

  assign w_h0_req = h0_read | h0_write;
  assign w_h1_req = h1_read | h1_write;
  // Tie goes to the host that did not win last time.
  assign w_win    = (w_h0_req & w_h1_req) ? ~r_last : w_h1_req;

  assign w_o_address    = r_owner ? h1_address    : h0_address;
  assign w_o_read       = r_owner ? h1_read       : h0_read;
  assign w_o_write      = r_owner ? h1_write      : h0_write;
  assign w_o_writedata  = r_owner ? h1_writedata  : h0_writedata;
  assign w_o_byteenable = r_owner ? h1_byteenable : h0_byteenable;
  assign w_o_burstcount = r_owner ? h1_burstcount : h0_burstcount;

  // Burstcount 0 behaves as a single beat.
  assign w_bc_norm = (w_o_burstcount == '0) ? BURSTCOUNT_W'(1) : w_o_burstcount;
  // On the first write beat len is not latched yet, so use the live burstcount.
  assign w_len_eff = (r_beats == '0) ? w_bc_norm : r_len;

  // State and arbitration registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_beats <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_beats <= w_beats_nxt;
      r_len   <= w_len_nxt;
    end
  end

  // Next-state: arbitration in IDLE, beat counting during transfers.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_beats_nxt = r_beats;
    w_len_nxt   = r_len;
    case (r_state)
      S_IDLE: begin
        if (w_h0_req | w_h1_req) begin
          w_owner_nxt = w_win;
          w_last_nxt  = w_win;
          w_state_nxt = (w_win ? h1_write : h0_write) ? S_WR : S_RD_REQ;
        end
      end
      S_WR: begin
        if ((r_beats == '0) && !w_o_read && !w_o_write) begin
          w_state_nxt = S_IDLE;
        end else if (w_o_write && !a_waitrequest) begin
          if (r_beats == '0) w_len_nxt = w_bc_norm;
          if (r_beats == (w_len_eff - BURSTCOUNT_W'(1))) begin
            w_beats_nxt = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_beats_nxt = r_beats + BURSTCOUNT_W'(1);
          end
        end
      end
      S_RD_REQ: begin
        if (!w_o_read && !w_o_write) begin
          w_state_nxt = S_IDLE;
        end else if (w_o_read && !a_waitrequest) begin
          w_len_nxt   = w_bc_norm;
          w_state_nxt = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (a_readdatavalid) begin
          if (r_beats == (r_len - BURSTCOUNT_W'(1))) begin
            w_beats_nxt = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_beats_nxt = r_beats + BURSTCOUNT_W'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output muxing: owner to agent, stall the other host, route read beats.
  always_comb begin
    a_address        = '0;
    a_read           = 1'b0;
    a_write          = 1'b0;
    a_writedata      = '0;
    a_byteenable     = '0;
    a_burstcount     = '0;
    h0_waitrequest   = 1'b1;
    h1_waitrequest   = 1'b1;
    h0_readdata      = '0;
    h1_readdata      = '0;
    h0_readdatavalid = 1'b0;
    h1_readdatavalid = 1'b0;
    grant            = 2'b00;
    if (r_state != S_IDLE) begin
      a_address    = w_o_address;
      a_read       = (r_state == S_RD_DATA) ? 1'b0 : w_o_read;
      a_write      = w_o_write;
      a_writedata  = w_o_writedata;
      a_byteenable = w_o_byteenable;
      a_burstcount = w_o_burstcount;
      grant        = r_owner ? 2'b10 : 2'b01;
      if (r_owner) h1_waitrequest = (r_state == S_RD_DATA) ? 1'b1 : a_waitrequest;
      else         h0_waitrequest = (r_state == S_RD_DATA) ? 1'b1 : a_waitrequest;
    end
    if (r_state == S_RD_DATA) begin
      if (r_owner) begin
        h1_readdata      = a_readdata;
        h1_readdatavalid = a_readdatavalid;
      end else begin
        h0_readdata      = a_readdata;
        h0_readdatavalid = a_readdatavalid;
      end
    end
  end

  // A host driving read and write together is illegal.
  h0_rd_wr_excl: assert property (@(posedge clk) disable iff (!reset_n) !(h0_read && h0_write));
  h1_rd_wr_excl: assert property (@(posedge clk) disable iff (!reset_n) !(h1_read && h1_write));

endmodule

// File: tb/tb_avalon_arbiter2.sv
// Testbench for avalon_arbiter2 with BURSTCOUNT_W=3: directed table, corner
// sequences and randomized transactions against a transaction-level model.
module tb_avalon_arbiter2;
  localparam int BW = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [31:0]   h0_address, h0_writedata, h0_readdata;
  logic          h0_read, h0_write, h0_waitrequest, h0_readdatavalid;
  logic [3:0]    h0_byteenable;
  logic [BW-1:0] h0_burstcount;
  logic [31:0]   h1_address, h1_writedata, h1_readdata;
  logic          h1_read, h1_write, h1_waitrequest, h1_readdatavalid;
  logic [3:0]    h1_byteenable;
  logic [BW-1:0] h1_burstcount;
  logic [31:0]   a_address, a_writedata, a_readdata;
  logic          a_read, a_write, a_waitrequest, a_readdatavalid;
  logic [3:0]    a_byteenable;
  logic [BW-1:0] a_burstcount;
  logic [1:0]    grant;

  avalon_arbiter2 #(.BURSTCOUNT_W(BW)) dut (
    .clk(clk), .reset_n(reset_n),
    .h0_address(h0_address), .h0_read(h0_read), .h0_write(h0_write),
    .h0_writedata(h0_writedata), .h0_byteenable(h0_byteenable),
    .h0_burstcount(h0_burstcount), .h0_waitrequest(h0_waitrequest),
    .h0_readdata(h0_readdata), .h0_readdatavalid(h0_readdatavalid),
    .h1_address(h1_address), .h1_read(h1_read), .h1_write(h1_write),
    .h1_writedata(h1_writedata), .h1_byteenable(h1_byteenable),
    .h1_burstcount(h1_burstcount), .h1_waitrequest(h1_waitrequest),
    .h1_readdata(h1_readdata), .h1_readdatavalid(h1_readdatavalid),
    .a_address(a_address), .a_read(a_read), .a_write(a_write),
    .a_writedata(a_writedata), .a_byteenable(a_byteenable),
    .a_burstcount(a_burstcount), .a_waitrequest(a_waitrequest),
    .a_readdata(a_readdata), .a_readdatavalid(a_readdatavalid),
    .grant(grant)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          model_last;     // host granted most recently (model view)
  logic [31:0] amem[8];        // agent-side memory, written through a_* only
  logic [31:0] mmem[8];        // reference memory, written from host intent
  logic [3:0]  hbe[2];

  typedef struct {
    int          t0, t1;       // 0 none, 1 read, 2 write
    int          w0, w1;       // word addresses
    logic [31:0] d;
    int          first;        // host expected to be granted first
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_host(input int h, input bit rd, input bit wr, input int word,
                          input int bc, input logic [31:0] d);
    logic [3:0] be;
    be = 4'($urandom_range(0, 15));
    hbe[h] = be;
    if (h == 0) begin
      h0_read = rd; h0_write = wr; h0_address = 32'(word * 4);
      h0_burstcount = BW'(bc); h0_writedata = d; h0_byteenable = be;
    end else begin
      h1_read = rd; h1_write = wr; h1_address = 32'(word * 4);
      h1_burstcount = BW'(bc); h1_writedata = d; h1_byteenable = be;
    end
  endtask

  task automatic drop(input int h);
    if (h == 0) begin h0_read = 1'b0; h0_write = 1'b0; end
    else        begin h1_read = 1'b0; h1_write = 1'b0; end
  endtask

  task automatic set_wdata(input int h, input logic [31:0] d);
    if (h == 0) h0_writedata = d; else h1_writedata = d;
  endtask

  function automatic logic wreq(input int h);
    return (h == 0) ? h0_waitrequest : h1_waitrequest;
  endfunction
  function automatic logic rdv(input int h);
    return (h == 0) ? h0_readdatavalid : h1_readdatavalid;
  endfunction
  function automatic logic [31:0] rdata(input int h);
    return (h == 0) ? h0_readdata : h1_readdata;
  endfunction

  // Runs one granted transaction for host h. Entered in IDLE just after a
  // negedge with h's request already driven; returns one negedge after the
  // DUT is expected back in IDLE.
  task automatic serve(input int h, input bit wr, input int word, input int bc,
                       input logic [31:0] d0, input bit rearm);
    int n = (bc == 0) ? 1 : bc;
    int beat = 0;
    int cyc = 0;
    int base = 0;
    bit acc = 0;
    logic v;
    logic [31:0] wd;
    logic [1:0] g = (h == 1) ? 2'b10 : 2'b01;
    model_last = h;
    if (wr) begin
      while (beat < n && cyc < 100) begin
        @(negedge clk);
        a_waitrequest = 1'($urandom_range(0, 1));
        a_readdatavalid = 1'($urandom_range(0, 1));
        a_readdata = $urandom;
        wd = d0 + 32'(beat) * 32'h01010101;
        set_wdata(h, wd);
        #1;
        chk("wr_grant", grant, g);
        chk("wr_a_write", a_write, 1);
        chk("wr_a_read", a_read, 0);
        chk("wr_a_address", a_address, 32'(word * 4));
        chk("wr_a_writedata", a_writedata, wd);
        chk("wr_a_byteenable", a_byteenable, hbe[h]);
        chk("wr_a_burstcount", a_burstcount, bc);
        chk("wr_owner_wait", wreq(h), a_waitrequest);
        chk("wr_other_wait", wreq(1 - h), 1);
        chk("wr_stray_rdv", {rdv(0), rdv(1)}, 0);
        acc = !a_waitrequest;
        if (acc) begin
          amem[(int'(a_address[4:2]) + beat) % 8] = a_writedata;
          mmem[(word + beat) % 8] = wd;
        end
        @(posedge clk); #1;
        if (acc) begin
          beat++;
          if (beat == n) drop(h);
        end
        cyc++;
      end
    end else begin
      while (!acc && cyc < 100) begin
        @(negedge clk);
        a_waitrequest = 1'($urandom_range(0, 1));
        a_readdatavalid = 1'($urandom_range(0, 1));
        a_readdata = $urandom;
        #1;
        chk("rq_grant", grant, g);
        chk("rq_a_read", a_read, 1);
        chk("rq_a_write", a_write, 0);
        chk("rq_a_address", a_address, 32'(word * 4));
        chk("rq_a_burstcount", a_burstcount, bc);
        chk("rq_owner_wait", wreq(h), a_waitrequest);
        chk("rq_other_wait", wreq(1 - h), 1);
        chk("rq_stray_rdv", {rdv(0), rdv(1)}, 0);
        acc = !a_waitrequest;
        if (acc) base = int'(a_address[4:2]);
        @(posedge clk); #1;
        if (acc && !rearm) drop(h);
        cyc++;
      end
      while (acc && beat < n && cyc < 200) begin
        @(negedge clk);
        v = 1'($urandom_range(0, 1));
        a_readdatavalid = v;
        a_readdata = v ? amem[(base + beat) % 8] : $urandom;
        a_waitrequest = 1'($urandom_range(0, 1));
        #1;
        chk("rd_grant", grant, g);
        chk("rd_a_read_forced0", a_read, 0);
        chk("rd_owner_wait", wreq(h), 1);
        chk("rd_other_wait", wreq(1 - h), 1);
        chk("rd_owner_rdv", rdv(h), v);
        chk("rd_other_rdv", rdv(1 - h), 0);
        chk("rd_other_data", rdata(1 - h), 0);
        if (v) chk("rd_data", rdata(h), mmem[(word + beat) % 8]);
        @(posedge clk); #1;
        if (v) beat++;
        cyc++;
      end
    end
    chk("txn_beats_done", beat, wr ? n : (acc ? n : -1));
    @(negedge clk);
    a_readdatavalid = 1'b1;   // stray beat while idle must be dropped
    a_readdata = $urandom;
    #1;
    chk("end_grant_idle", grant, 0);
    chk("end_a_cmd_idle", {a_read, a_write}, 0);
    chk("end_wait_idle", {h0_waitrequest, h1_waitrequest}, 2'b11);
    chk("end_stray_rdv", {h0_readdatavalid, h1_readdatavalid}, 0);
    a_readdatavalid = 1'b0;
  endtask

  // Drives both hosts at once, serves the expected winner then the loser.
  task automatic run_pair(input int t0, input int t1, input int w0, input int w1,
                          input int bc0, input int bc1, input logic [31:0] d0,
                          input logic [31:0] d1, input int first);
    set_host(0, t0 == 1, t0 == 2, w0, bc0, d0);
    set_host(1, t1 == 1, t1 == 2, w1, bc1, d1);
    if (first == 0) begin
      serve(0, t0 == 2, w0, bc0, d0, 1'b0);
      if (t1 != 0) serve(1, t1 == 2, w1, bc1, d1, 1'b0);
    end else begin
      serve(1, t1 == 2, w1, bc1, d1, 1'b0);
      if (t0 != 0) serve(0, t0 == 2, w0, bc0, d0, 1'b0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, first;
    for (int i = 0; i < 8; i++) begin
      amem[i] = 32'(i) * 32'h11111111;
      mmem[i] = 32'(i) * 32'h11111111;
    end
    tbl[0] = '{2, 0, 4, 0, 32'hDEADBEEF, 0};
    tbl[1] = '{0, 1, 0, 4, 32'h00000000, 1};
    tbl[2] = '{1, 1, 1, 2, 32'h00000000, 0};
    tbl[3] = '{1, 2, 3, 5, 32'h12345678, 0};
    tbl[4] = '{0, 2, 0, 6, 32'hA5A5A5A5, 1};
    tbl[5] = '{2, 2, 7, 0, 32'h0BADF00D, 0};
    tbl[6] = '{1, 0, 4, 0, 32'h00000000, 0};
    tbl[7] = '{1, 1, 5, 6, 32'h00000000, 1};

    // Reset with both hosts requesting.
    a_waitrequest = 1'b0; a_readdatavalid = 1'b1; a_readdata = 32'h55AA55AA;
    set_host(0, 1, 0, 1, 1, 0);
    set_host(1, 1, 0, 2, 1, 0);
    reset_n = 1'b0;
    #22;
    chk("rst_grant", grant, 0);
    chk("rst_a_cmd", {a_read, a_write}, 0);
    chk("rst_a_address", a_address, 0);
    chk("rst_wait", {h0_waitrequest, h1_waitrequest}, 2'b11);
    chk("rst_rdv", {h0_readdatavalid, h1_readdatavalid}, 0);
    chk("rst_rdata0", h0_readdata, 0);
    a_readdatavalid = 1'b0;
    @(negedge clk); reset_n = 1'b1; #1;
    model_last = 1;
    serve(0, 0, 1, 1, 0, 1'b0);
    serve(1, 0, 2, 1, 0, 1'b0);

    // Directed arbitration table (single-beat transactions).
    for (int i = 0; i < 8; i++)
      run_pair(tbl[i].t0, tbl[i].t1, tbl[i].w0, tbl[i].w1, 1, 1,
               tbl[i].d, ~tbl[i].d, tbl[i].first);
    chk("readback_deadbeef", mmem[4], 32'hDEADBEEF);

    // 4-beat h1 write burst while h0 also writes, then 4-beat h1 read burst.
    run_pair(2, 2, 0, 2, 1, 4, 32'h01020304, 32'hC0DE0000, 1);
    run_pair(0, 1, 0, 2, 1, 4, 0, 0, 1);

    // Continuous contention: grants must alternate 0,1,0,1,0,1.
    set_host(0, 1, 0, 1, 1, 0);
    set_host(1, 1, 0, 3, 1, 0);
    for (int i = 0; i < 6; i++)
      serve(i % 2, 1'b0, (i % 2 == 0) ? 1 : 3, 1, 0, 1'b1);
    drop(0); drop(1);

    // Abandon in RD_REQ: h0 drops before acceptance, then a tie goes to h1.
    @(negedge clk);
    set_host(0, 1, 0, 3, 1, 0);
    @(negedge clk); a_waitrequest = 1'b1; #1;
    chk("ab_grant", grant, 2'b01);
    chk("ab_a_read", a_read, 1);
    @(posedge clk); #1;
    drop(0);
    set_host(1, 1, 0, 4, 1, 0);
    @(negedge clk); #1;
    chk("ab_still_owner", grant, 2'b01);
    chk("ab_h1_wait", h1_waitrequest, 1);
    @(posedge clk); #1;
    set_host(0, 1, 0, 3, 1, 0);
    @(negedge clk); #1;
    chk("ab_idle", grant, 0);
    serve(1, 1'b0, 4, 1, 0, 1'b0);
    serve(0, 1'b0, 3, 1, 0, 1'b0);

    // Reset asserted during RD_DATA takes effect without a clock edge.
    set_host(0, 1, 0, 2, 1, 0);
    @(negedge clk); a_waitrequest = 1'b0; #1;
    chk("rr_grant", grant, 2'b01);
    @(posedge clk); #1;
    drop(0);
    @(negedge clk); a_readdatavalid = 1'b1; a_readdata = 32'hCAFEF00D; #1;
    chk("rr_pre_rdv", h0_readdatavalid, 1);
    chk("rr_pre_data", h0_readdata, 32'hCAFEF00D);
    set_host(1, 0, 1, 5, 1, 32'h77);
    reset_n = 1'b0; #1;
    chk("rr_grant0", grant, 0);
    chk("rr_a_cmd", {a_read, a_write}, 0);
    chk("rr_wait", {h0_waitrequest, h1_waitrequest}, 2'b11);
    chk("rr_rdv", {h0_readdatavalid, h1_readdatavalid}, 0);
    chk("rr_rdata", h0_readdata, 0);
    a_readdatavalid = 1'b0;
    drop(1);
    @(negedge clk); reset_n = 1'b1; #1;
    model_last = 1;
    run_pair(1, 1, 6, 7, 1, 1, 0, 0, 0);

    // Randomized transactions against the model.
    for (int i = 0; i < 40; i++) begin
      t0 = $urandom_range(0, 2);
      t1 = $urandom_range(0, 2);
      if (t0 == 0 && t1 == 0) t0 = 2;
      if (t0 != 0 && t1 != 0) first = 1 - model_last;
      else                    first = (t0 != 0) ? 0 : 1;
      run_pair(t0, t1, $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 4), $urandom_range(0, 4), $urandom, $urandom, first);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
